// File: rtl/de2_115_debounced_input_port_if.sv
// rtl/de2_115_debounced_input_port_if.sv - Avalon-MM slave bus bundle for the debounced input port
interface de2_115_debounced_input_port_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/de2_115_debounced_input_port.sv
// rtl/de2_115_debounced_input_port.sv - synchronised, debounced input bank with edge capture and irq
// Define DE2_INPUT_RAW_READ_EN to expose the synchronised pre-debounce vector at address 1.
module de2_115_debounced_input_port #(
  parameter int          DW              = 18,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_TYPE       = 2,
  parameter logic [31:0] INIT_VAL        = 32'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DW-1:0]                 pins,
  de2_115_debounced_input_port_if.slave avs,
  output logic                          irq
);
  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] sync1_q, sync2_q;
  logic [DW-1:0] stable_q, stable_d;
  logic [CW-1:0] cnt_q [DW];
  logic [CW-1:0] cnt_d [DW];
  logic [DW-1:0] edgecap_q, edgecap_d;
  logic [DW-1:0] mask_q, mask_d;
  logic [DW-1:0] edge_hit;
  logic [31:0]   readdata_q, readdata_d, rd_mux;
  logic          irq_q, irq_d;
  logic          wr_en, rd_en;
  logic          unused_wdata;

  assign unused_wdata = ^avs.writedata;

  // A bit only flips after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int b = 0; b < DW; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == CNT_MAX) begin
          stable_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_hit = stable_d & ~stable_q;
      1:       edge_hit = ~stable_d & stable_q;
      default: edge_hit = stable_d ^ stable_q;
    endcase
  end

  always_comb begin
    wr_en     = avs.chipselect & avs.write;
    rd_en     = avs.chipselect & avs.read;
    mask_d    = mask_q;
    edgecap_d = edgecap_q;
    if (wr_en && avs.address == 2'd2) begin
      mask_d = avs.writedata[DW-1:0];
    end
    if (wr_en && avs.address == 2'd3) begin
      edgecap_d = edgecap_q & ~avs.writedata[DW-1:0];
    end
    // New edges are ORed in after the clear so a same-cycle set survives.
    edgecap_d = edgecap_d | edge_hit;

    rd_mux = '0;
    case (avs.address)
      2'd0:    rd_mux = 32'(stable_q);
`ifdef DE2_INPUT_RAW_READ_EN
      2'd1:    rd_mux = 32'(sync2_q);
`endif
      2'd2:    rd_mux = 32'(mask_q);
      2'd3:    rd_mux = 32'(edgecap_q);
      default: rd_mux = '0;
    endcase
    readdata_d = rd_en ? rd_mux : readdata_q;
    irq_d      = |(edgecap_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= INIT_VAL[DW-1:0];
      sync2_q    <= INIT_VAL[DW-1:0];
      stable_q   <= INIT_VAL[DW-1:0];
      edgecap_q  <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int b = 0; b < DW; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      sync1_q    <= pins;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      edgecap_q  <= edgecap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int b = 0; b < DW; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_de2_115_debounced_input_port.sv
// tb/tb_de2_115_debounced_input_port.sv - table vectors plus random stimulus against a reference model
module tb_de2_115_debounced_input_port;
  localparam int D = 4;
`ifdef DE2_INPUT_RAW_READ_EN
  localparam bit RAW_EN = 1'b1;
`else
  localparam bit RAW_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pins [3];
  logic [1:0]  address;
  logic        cs, rd, wr;
  logic [31:0] wdata;
  logic        irq0, irq1, irq2;

  de2_115_debounced_input_port_if bus0 ();
  de2_115_debounced_input_port_if bus1 ();
  de2_115_debounced_input_port_if bus2 ();

  assign bus0.address = address; assign bus0.chipselect = cs; assign bus0.read = rd;
  assign bus0.write = wr; assign bus0.writedata = wdata;
  assign bus1.address = address; assign bus1.chipselect = cs; assign bus1.read = rd;
  assign bus1.write = wr; assign bus1.writedata = wdata;
  assign bus2.address = address; assign bus2.chipselect = cs; assign bus2.read = rd;
  assign bus2.write = wr; assign bus2.writedata = wdata;

  de2_115_debounced_input_port #(.DW(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .INIT_VAL(32'h0)) u0 (
    .clk(clk), .reset(reset), .pins(pins[0]), .avs(bus0), .irq(irq0));
  de2_115_debounced_input_port #(.DW(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0), .INIT_VAL(32'h0)) u1 (
    .clk(clk), .reset(reset), .pins(pins[1]), .avs(bus1), .irq(irq1));
  de2_115_debounced_input_port #(.DW(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .INIT_VAL(32'hF)) u2 (
    .clk(clk), .reset(reset), .pins(pins[2]), .avs(bus2), .irq(irq2));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int         m_type [3] = '{2, 0, 1};
  logic [3:0] m_init [3] = '{4'h0, 4'h0, 4'hF};
  logic [3:0] m_stable [3];
  logic [3:0] m_ec [3];
  logic [3:0] m_mask [3];
  logic [31:0] m_rd [3];
  logic       m_irq [3];
  logic [3:0] samp [3][8];

  typedef struct {
    bit          rst;
    logic [3:0]  p01;
    logic [3:0]  p2;
    int          op;
    logic [1:0]  addr;
    logic [31:0] wd;
    int          n;
    bit          chk;
    logic [31:0] e0, e1, e2;
    logic        eirq1;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] get_rd(input int i);
    case (i)
      0:       return bus0.readdata;
      1:       return bus1.readdata;
      default: return bus2.readdata;
    endcase
  endfunction

  function automatic logic get_irq(input int i);
    case (i)
      0:       return irq0;
      1:       return irq1;
      default: return irq2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a level is accepted once the last D synchronised samples all disagree with it.
  task automatic step();
    logic [3:0] nst, sel, sy;
    bit all_diff;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_stable[i] = m_init[i];
        m_ec[i] = 4'h0;
        m_mask[i] = 4'h0;
        m_rd[i] = 32'h0;
        m_irq[i] = 1'b0;
        for (int j = 0; j < 8; j++) samp[i][j] = m_init[i];
      end else begin
        sy = samp[i][1];
        if (cs && rd) begin
          case (address)
            2'd0: m_rd[i] = {28'h0, m_stable[i]};
            2'd1: m_rd[i] = RAW_EN ? {28'h0, sy} : 32'h0;
            2'd2: m_rd[i] = {28'h0, m_mask[i]};
            default: m_rd[i] = {28'h0, m_ec[i]};
          endcase
        end
        m_irq[i] = |(m_ec[i] & m_mask[i]);
        nst = m_stable[i];
        for (int b = 0; b < 4; b++) begin
          all_diff = 1'b1;
          for (int j = 1; j <= D; j++) if (samp[i][j][b] == m_stable[i][b]) all_diff = 1'b0;
          if (all_diff) nst[b] = ~m_stable[i][b];
        end
        if (m_type[i] == 0)      sel = nst & ~m_stable[i];
        else if (m_type[i] == 1) sel = ~nst & m_stable[i];
        else                     sel = nst ^ m_stable[i];
        if (cs && wr && address == 2'd3) m_ec[i] = m_ec[i] & ~wdata[3:0];
        m_ec[i] = m_ec[i] | sel;
        if (cs && wr && address == 2'd2) m_mask[i] = wdata[3:0];
        m_stable[i] = nst;
        for (int j = 7; j > 0; j--) samp[i][j] = samp[i][j-1];
        samp[i][0] = pins[i];
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model rd%0d", i), get_rd(i), m_rd[i]);
      check($sformatf("model irq%0d", i), {31'h0, get_irq(i)}, {31'h0, m_irq[i]});
    end
  endtask

  task automatic add(input bit rst, input logic [3:0] p01, input logic [3:0] p2, input int op,
                     input logic [1:0] a, input logic [31:0] wd, input int n, input bit chk,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                     input logic ei);
    vec_t v;
    v = '{rst, p01, p2, op, a, wd, n, chk, e0, e1, e2, ei};
    vq.push_back(v);
  endtask

  initial begin
    vec_t v;
    logic [31:0] raw5, rawf;
    raw5 = RAW_EN ? 32'h5 : 32'h0;
    rawf = RAW_EN ? 32'hF : 32'h0;
    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; address = 2'd0; wdata = 32'h0;
    pins[0] = 4'h0; pins[1] = 4'h0; pins[2] = 4'hF;

    //   rst p01   p2    op a  wd     n   chk e0     e1     e2     irq1
    add(1, 4'h0, 4'hF, 0, 0, 32'h0, 3,  1,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h1, 4'hF, 0, 0, 32'h0, 5,  0,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h1, 4'hF, 1, 0, 32'h0, 1,  1,  32'h0, 32'h0, 32'hF, 0);
    add(0, 4'h1, 4'hF, 1, 0, 32'h0, 1,  1,  32'h1, 32'h1, 32'hF, 0);
    add(0, 4'h1, 4'hF, 1, 3, 32'h0, 1,  1,  32'h1, 32'h1, 32'h0, 0);
    add(0, 4'h1, 4'hF, 2, 2, 32'h1, 1,  1,  32'h1, 32'h1, 32'h0, 0);
    add(0, 4'h1, 4'hF, 0, 0, 32'h0, 1,  1,  32'h1, 32'h1, 32'h0, 1);
    add(0, 4'h1, 4'hF, 2, 3, 32'h1, 1,  1,  32'h1, 32'h1, 32'h0, 1);
    add(0, 4'h1, 4'hF, 0, 0, 32'h0, 1,  1,  32'h1, 32'h1, 32'h0, 0);
    add(0, 4'h1, 4'hF, 1, 3, 32'h0, 1,  1,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h0, 4'hF, 0, 0, 32'h0, 6,  0,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h0, 4'hF, 1, 3, 32'h0, 1,  1,  32'h1, 32'h0, 32'h0, 0);
    add(0, 4'h0, 4'hF, 2, 3, 32'hF, 1,  1,  32'h1, 32'h0, 32'h0, 0);
    add(0, 4'h1, 4'hF, 0, 0, 32'h0, 3,  0,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h0, 4'hF, 0, 0, 32'h0, 6,  0,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h0, 4'hF, 1, 0, 32'h0, 1,  1,  32'h0, 32'h0, 32'hF, 0);
    add(0, 4'h0, 4'hF, 1, 3, 32'h0, 1,  1,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h0, 4'hB, 0, 0, 32'h0, 10, 0,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h0, 4'hB, 1, 0, 32'h0, 1,  1,  32'h0, 32'h0, 32'hB, 0);
    add(0, 4'h0, 4'hB, 1, 3, 32'h0, 1,  1,  32'h0, 32'h0, 32'h4, 0);
    add(0, 4'h1, 4'hB, 0, 0, 32'h0, 5,  0,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h1, 4'hB, 2, 3, 32'h1, 1,  1,  32'h0, 32'h0, 32'h4, 0);
    add(0, 4'h1, 4'hB, 1, 3, 32'h0, 1,  1,  32'h1, 32'h1, 32'h4, 1);
    add(1, 4'h0, 4'hF, 0, 0, 32'h0, 2,  1,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h5, 4'hF, 0, 0, 32'h0, 3,  0,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h5, 4'hF, 1, 1, 32'h0, 1,  1,  raw5,  raw5,  rawf,  0);
    add(0, 4'h5, 4'hF, 1, 0, 32'h0, 1,  1,  32'h0, 32'h0, 32'hF, 0);
    add(0, 4'h5, 4'hF, 1, 3, 32'h0, 1,  1,  32'h0, 32'h0, 32'h0, 0);
    add(0, 4'h5, 4'hF, 1, 3, 32'h0, 1,  1,  32'h5, 32'h5, 32'h0, 0);

    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      reset = v.rst;
      pins[0] = v.p01; pins[1] = v.p01; pins[2] = v.p2;
      cs = (v.op != 0); rd = (v.op == 1); wr = (v.op == 2);
      address = v.addr; wdata = v.wd;
      repeat (v.n) step();
      if (v.chk) begin
        check($sformatf("vec%0d rd0", k), bus0.readdata, v.e0);
        check($sformatf("vec%0d rd1", k), bus1.readdata, v.e1);
        check($sformatf("vec%0d rd2", k), bus2.readdata, v.e2);
        check($sformatf("vec%0d irq1", k), {31'h0, irq1}, {31'h0, v.eirq1});
      end
    end

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++)
        for (int b = 0; b < 4; b++)
          if ($urandom_range(0, 5) == 0) pins[i][b] = ~pins[i][b];
      cs = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b0; wr = 1'b0; end
      endcase
      address = 2'($urandom_range(0, 3));
      wdata = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
